// File: rtl/zero_cross_meter_pkg.sv
// -----------------------------------------------------------------------------
// zero_cross_meter_pkg
// Shared definitions for the zero-crossing period meter.
//   EDGE_RISE / EDGE_FALL / EDGE_BOTH : values of the EDGE_MODE parameter
//   zc_state_e                        : measurement FSM state encoding
//   edge_select()                     : picks the qualifying crossing for a mode
// -----------------------------------------------------------------------------
package zero_cross_meter_pkg;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // sign of the input not yet known
        ST_ARMED = 2'd1,   // sign known, waiting for the first qualifying crossing
        ST_MEAS  = 2'd2    // reference crossing seen, counting samples
    } zc_state_e;

    // Reduce the raw rise/fall indications to the crossing selected by the mode.
    // Unknown modes fall back to rising-edge behaviour.
    function automatic logic edge_select(input int mode, input logic rise, input logic fall);
        logic sel;
        case (mode)
            EDGE_RISE: sel = rise;
            EDGE_FALL: sel = fall;
            EDGE_BOTH: sel = rise | fall;
            default:   sel = rise;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/zero_cross_meter_sign_tracker.sv
// -----------------------------------------------------------------------------
// zero_cross_meter_sign_tracker
// Hysteresis comparator plus the registered sign of the input stream.
//   clk, reset   : clock, synchronous active-high reset
//   in_valid     : x carries a new sample this cycle
//   x            : signed input sample
//   sign_known   : registered; a sample outside the dead band has been seen
//   rise / fall  : combinational; the current valid sample flips the tracked
//                  sign NEG->POS / POS->NEG
//   outside      : combinational; the current sample lies outside [-HYST,+HYST]
// -----------------------------------------------------------------------------
module zero_cross_meter_sign_tracker #(
    parameter int DATA_W = 32,
    parameter int HYST   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] x,
    output logic                     sign_known,
    output logic                     rise,
    output logic                     fall,
    output logic                     outside
);

    // One extra bit so that -HYST and the most negative sample both fit.
    localparam logic signed [DATA_W:0] HYST_P = (DATA_W + 1)'(HYST);
    localparam logic signed [DATA_W:0] HYST_N = -HYST_P;

    logic signed [DATA_W:0] w_x_ext;
    logic                   w_pos;
    logic                   w_neg;
    logic                   r_sign;    // 1 = positive, 0 = negative
    logic                   r_known;

    assign w_x_ext = {x[DATA_W-1], x};
    assign w_pos   = (w_x_ext > HYST_P);
    assign w_neg   = (w_x_ext < HYST_N);

    assign outside    = w_pos | w_neg;
    assign sign_known = r_known;
    assign rise       = in_valid & r_known & ~r_sign & w_pos;
    assign fall       = in_valid & r_known &  r_sign & w_neg;

    // Tracked sign: only samples outside the dead band may move it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sign  <= 1'b0;
            r_known <= 1'b0;
        end else if (in_valid && (w_pos || w_neg)) begin
            r_sign  <= w_pos;
            r_known <= 1'b1;
        end else begin
            r_sign  <= r_sign;
            r_known <= r_known;
        end
    end

endmodule

// File: rtl/zero_cross_meter.sv
// -----------------------------------------------------------------------------
// zero_cross_meter
// Zero-crossing period meter with hysteresis, edge selection, overflow
// detection and block averaging over 2^AVG_LOG2 periods.
//   clk, reset    : clock, synchronous active-high reset
//   in_valid, x   : sample strobe and signed sample; state advances only on in_valid
//   flag          : 1-cycle pulse, qualifying crossing seen
//   period        : samples between the last two qualifying crossings
//   period_valid  : 1-cycle pulse, period updated
//   avg_period    : truncated mean of the last 2^AVG_LOG2 periods
//   avg_valid     : 1-cycle pulse, avg_period updated
//   overflow      : 1-cycle pulse, counter saturated without a crossing
//   locked        : at least one period measured since reset/overflow
// All outputs are registered: a sample accepted in cycle t shows up in t+1.
// -----------------------------------------------------------------------------
module zero_cross_meter
    import zero_cross_meter_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 10,
    parameter int HYST      = 0,
    parameter int EDGE_MODE = 0,
    parameter int AVG_LOG2  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] x,
    output logic                     flag,
    output logic [CNT_W-1:0]         period,
    output logic                     period_valid,
    output logic [CNT_W-1:0]         avg_period,
    output logic                     avg_valid,
    output logic                     overflow,
    output logic                     locked
);

    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    // The counter stops one below all-ones so that counter+1 (the period)
    // still fits in CNT_W bits when a crossing arrives at saturation.
    localparam logic [CNT_W-1:0] CNT_SAT  = {{(CNT_W - 1){1'b1}}, 1'b0};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);

    // Sign tracker interface
    logic w_sign_known;
    logic w_rise;
    logic w_fall;
    logic w_outside;
    logic w_cross;

    // FSM
    zc_state_e r_state;
    zc_state_e w_state_nxt;

    // Datapath state and output registers
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic [IDX_W-1:0] r_idx;
    logic             r_flag;
    logic [CNT_W-1:0] r_period;
    logic             r_pv;
    logic [CNT_W-1:0] r_avg;
    logic             r_av;
    logic             r_ovf;
    logic             r_locked;

    // Next values
    logic [CNT_W-1:0] w_cnt_d;
    logic [ACC_W-1:0] w_acc_d;
    logic [IDX_W-1:0] w_idx_d;
    logic             w_flag_d;
    logic [CNT_W-1:0] w_period_d;
    logic             w_pv_d;
    logic [CNT_W-1:0] w_avg_d;
    logic             w_av_d;
    logic             w_ovf_d;
    logic             w_locked_d;

    logic [CNT_W-1:0] w_period_new;
    logic [ACC_W-1:0] w_sum;

    zero_cross_meter_sign_tracker #(
        .DATA_W (DATA_W),
        .HYST   (HYST)
    ) u_sign (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .x          (x),
        .sign_known (w_sign_known),
        .rise       (w_rise),
        .fall       (w_fall),
        .outside    (w_outside)
    );

    // rise/fall are already qualified by in_valid inside the tracker.
    assign w_cross      = w_sign_known & edge_select(EDGE_MODE, w_rise, w_fall);
    assign w_period_new = r_cnt + CNT_W'(1);
    assign w_sum        = r_acc + ACC_W'(w_period_new);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid && w_outside) begin
                    w_state_nxt = ST_ARMED;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (w_cross) begin
                    w_state_nxt = ST_MEAS;
                end else begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_MEAS: begin
                if (in_valid && !w_cross && (r_cnt == CNT_SAT)) begin
                    w_state_nxt = ST_ARMED;
                end else begin
                    w_state_nxt = ST_MEAS;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output / datapath next values: counter, accumulator and output registers.
    always_comb begin
        w_flag_d   = 1'b0;
        w_pv_d     = 1'b0;
        w_av_d     = 1'b0;
        w_ovf_d    = 1'b0;
        w_period_d = r_period;
        w_avg_d    = r_avg;
        w_locked_d = r_locked;
        w_cnt_d    = r_cnt;
        w_acc_d    = r_acc;
        w_idx_d    = r_idx;
        case (r_state)
            ST_IDLE: begin
                w_cnt_d = {CNT_W{1'b0}};
            end
            ST_ARMED: begin
                if (w_cross) begin
                    // First qualifying crossing only establishes the reference.
                    w_flag_d = 1'b1;
                    w_cnt_d  = {CNT_W{1'b0}};
                end else begin
                    w_cnt_d  = r_cnt;
                end
            end
            ST_MEAS: begin
                if (w_cross) begin
                    w_flag_d   = 1'b1;
                    w_pv_d     = 1'b1;
                    w_period_d = w_period_new;
                    w_locked_d = 1'b1;
                    w_cnt_d    = {CNT_W{1'b0}};
                    if (r_idx == IDX_LAST) begin
                        // Block complete: publish the mean and start a fresh block.
                        w_avg_d = CNT_W'(w_sum >> AVG_LOG2);
                        w_av_d  = 1'b1;
                        w_acc_d = {ACC_W{1'b0}};
                        w_idx_d = {IDX_W{1'b0}};
                    end else begin
                        w_acc_d = w_sum;
                        w_idx_d = r_idx + IDX_W'(1);
                    end
                end else if (in_valid) begin
                    if (r_cnt == CNT_SAT) begin
                        // No crossing within the measurable range: drop lock and
                        // any partial average, re-arm on the retained sign.
                        w_ovf_d    = 1'b1;
                        w_locked_d = 1'b0;
                        w_cnt_d    = {CNT_W{1'b0}};
                        w_acc_d    = {ACC_W{1'b0}};
                        w_idx_d    = {IDX_W{1'b0}};
                    end else begin
                        w_cnt_d    = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_cnt_d = r_cnt;
                end
            end
            default: begin
                w_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_acc    <= {ACC_W{1'b0}};
            r_idx    <= {IDX_W{1'b0}};
            r_flag   <= 1'b0;
            r_period <= {CNT_W{1'b0}};
            r_pv     <= 1'b0;
            r_avg    <= {CNT_W{1'b0}};
            r_av     <= 1'b0;
            r_ovf    <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_d;
            r_acc    <= w_acc_d;
            r_idx    <= w_idx_d;
            r_flag   <= w_flag_d;
            r_period <= w_period_d;
            r_pv     <= w_pv_d;
            r_avg    <= w_avg_d;
            r_av     <= w_av_d;
            r_ovf    <= w_ovf_d;
            r_locked <= w_locked_d;
        end
    end

    assign flag         = r_flag;
    assign period       = r_period;
    assign period_valid = r_pv;
    assign avg_period   = r_avg;
    assign avg_valid    = r_av;
    assign overflow     = r_ovf;
    assign locked       = r_locked;

endmodule
